// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// opcode/funct constants, ALU control codes and datapath mux select values.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States in which the memory handshake can stall the FSM.
  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master;
// the datapath side (or a testbench) uses the slave modport.
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_en, i_or_d, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, mem_timeout,
           state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_en, i_or_d, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, mem_timeout,
           state_o
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// ALU control decode: aluop selects add/sub directly or defers to funct.
// funct_valid flags whether funct names a supported R-type operation.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  logic [2:0] funct_ctl;

  // Map funct to an ALU code, then pick by aluop.
  always_comb begin
    funct_ctl   = ALU_AND;
    funct_valid = 1'b1;
    alu_control = ALU_ADD;
    case (funct)
      FN_ADD:  funct_ctl = ALU_ADD;
      FN_SUB:  funct_ctl = ALU_SUB;
      FN_AND:  funct_ctl = ALU_AND;
      FN_OR:   funct_ctl = ALU_OR;
      FN_SLT:  funct_ctl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
    case (aluop)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_ctl;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: Moore decode of the state plus mem_ready/zero
// gated enables, wait-state counting and a sticky memory-timeout flag.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_mc_controller_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  aluop_t     aluop;
  logic       funct_valid;
  logic       pc_write, branch, mem_write, ir_write, reg_write, illegal;
  logic       i_or_d, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;

  mips_alu_decoder u_alu_dec (
    .aluop       (aluop),
    .funct       (bus.funct),
    .alu_control (bus.alu_control),
    .funct_valid (funct_valid)
  );

  // State, wait counter and timeout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      wait_cnt_q    <= {CNT_W{1'b0}};
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    i_or_d     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else begin
          state_d  = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          OP_RTYPE: begin
            if (funct_valid) begin
              state_d = RTYPEEX;
            end else begin
              state_d = FETCH;
              illegal = 1'b1;
            end
          end
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (bus.op == OP_LW) begin
          state_d = MEMRD;
        end else begin
          state_d = MEMWR;
        end
      end
      MEMRD: begin
        i_or_d = 1'b1;
        if (bus.mem_ready) begin
          state_d = MEMWB;
        end else begin
          state_d = MEMRD;
        end
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          state_d = FETCH;
        end else begin
          state_d = MEMWR;
        end
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = RTYPEWB;
      end
      RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JEX: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Wait counting: any cycle not stalled in a memory state restarts the count,
  // which also clears it on every entry into FETCH/MEMRD/MEMWR.
  always_comb begin
    wait_cnt_d = {CNT_W{1'b0}};
    if (is_mem_state(state_q) && !bus.mem_ready) begin
      if (wait_cnt_q == CNT_MAX) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end else begin
      wait_cnt_d = {CNT_W{1'b0}};
    end
    mem_timeout_d = mem_timeout_q | (wait_cnt_d >= CNT_W'(TIMEOUT_CYCLES));
  end

  // Strobes are suppressed for the whole reset window, not just after the edge.
  assign bus.pc_en       = (pc_write | (branch & bus.zero)) & ~rst;
  assign bus.mem_write   = mem_write & ~rst;
  assign bus.ir_write    = ir_write & ~rst;
  assign bus.reg_write   = reg_write & ~rst;
  assign bus.illegal_op  = illegal & ~rst;
  assign bus.i_or_d      = i_or_d;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.pc_src      = pc_src;
  assign bus.mem_timeout = mem_timeout_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: instruction-level sequence model checked every
// cycle, with directed scenarios that pin literal expectations on top.
module tb_mips_mc_controller;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_mc_controller_if bus ();

  mips_mc_controller #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: current state plus the remaining states of the instruction.
  state_t m_state = FETCH;
  state_t m_rest[$];
  int     m_wait = 0;
  bit     m_timeout = 1'b0;

  // Literal expectations for the current cycle (-1 = not pinned).
  int pin_state = -1;
  int pin_strb  = -1;
  int pin_alu   = -1;
  int pin_tmo   = -1;

  function automatic int funct_code(logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic bit is_legal(logic [5:0] o, logic [5:0] f);
    if (o == 6'b000000) return funct_code(f) >= 0;
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000100) ||
           (o == 6'b001000) || (o == 6'b000010);
  endfunction

  task automatic model_reset();
    m_state   = FETCH;
    m_rest.delete();
    m_wait    = 0;
    m_timeout = 1'b0;
  endtask

  task automatic model_advance();
    if (rst) begin
      model_reset();
    end else if ((m_state == FETCH || m_state == MEMRD || m_state == MEMWR) && !bus.mem_ready) begin
      if (m_wait < 31) m_wait++;
      if (m_wait >= 16) m_timeout = 1'b1;
    end else begin
      m_wait = 0;
      if (m_state == DECODE) begin
        case (bus.op)
          6'b100011: m_rest = '{MEMADR, MEMRD, MEMWB};
          6'b101011: m_rest = '{MEMADR, MEMWR};
          6'b000000: if (funct_code(bus.funct) >= 0) m_rest = '{RTYPEEX, RTYPEWB};
          6'b000100: m_rest = '{BEQEX};
          6'b001000: m_rest = '{ADDIEX, ADDIWB};
          6'b000010: m_rest = '{JEX};
          default: ;
        endcase
      end
      if (m_state == FETCH) m_state = DECODE;
      else if (m_rest.size() > 0) m_state = m_rest.pop_front();
      else m_state = FETCH;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (model state %0d) at %0t", name, act, exp, int'(m_state), $time);
    end
  endtask

  // Compare process: every negedge, DUT outputs against the model and pins.
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit rdy, on;
        int strb;
        rdy = bus.mem_ready;
        on  = !rst;
        chk("state_o", int'(bus.state_o), int'(m_state));
        chk("pc_en", int'(bus.pc_en), int'(on && ((m_state == FETCH && rdy) || m_state == JEX || (m_state == BEQEX && bus.zero))));
        chk("mem_write", int'(bus.mem_write), int'(on && m_state == MEMWR));
        chk("ir_write", int'(bus.ir_write), int'(on && m_state == FETCH && rdy));
        chk("reg_write", int'(bus.reg_write), int'(on && (m_state == MEMWB || m_state == RTYPEWB || m_state == ADDIWB)));
        chk("illegal_op", int'(bus.illegal_op), int'(on && m_state == DECODE && !is_legal(bus.op, bus.funct)));
        chk("mem_timeout", int'(bus.mem_timeout), int'(m_timeout));
        case (m_state)
          FETCH: begin
            chk("i_or_d", int'(bus.i_or_d), 0);
            chk("alu_src_a", int'(bus.alu_src_a), 0);
            chk("alu_src_b", int'(bus.alu_src_b), 1);
            chk("alu_control", int'(bus.alu_control), 2);
            chk("pc_src", int'(bus.pc_src), 0);
          end
          DECODE: begin
            chk("alu_src_a", int'(bus.alu_src_a), 0);
            chk("alu_src_b", int'(bus.alu_src_b), 3);
            chk("alu_control", int'(bus.alu_control), 2);
          end
          MEMADR, ADDIEX: begin
            chk("alu_src_a", int'(bus.alu_src_a), 1);
            chk("alu_src_b", int'(bus.alu_src_b), 2);
            chk("alu_control", int'(bus.alu_control), 2);
          end
          MEMRD, MEMWR: chk("i_or_d", int'(bus.i_or_d), 1);
          MEMWB: begin
            chk("reg_dst", int'(bus.reg_dst), 0);
            chk("mem_to_reg", int'(bus.mem_to_reg), 1);
          end
          RTYPEEX: begin
            chk("alu_src_a", int'(bus.alu_src_a), 1);
            chk("alu_src_b", int'(bus.alu_src_b), 0);
            chk("alu_control", int'(bus.alu_control), funct_code(bus.funct));
          end
          RTYPEWB, ADDIWB: begin
            chk("reg_dst", int'(bus.reg_dst), (m_state == RTYPEWB) ? 1 : 0);
            chk("mem_to_reg", int'(bus.mem_to_reg), 0);
          end
          BEQEX: begin
            chk("alu_src_a", int'(bus.alu_src_a), 1);
            chk("alu_src_b", int'(bus.alu_src_b), 0);
            chk("alu_control", int'(bus.alu_control), 6);
            chk("pc_src", int'(bus.pc_src), 1);
          end
          JEX: chk("pc_src", int'(bus.pc_src), 2);
          default: ;
        endcase
        strb = int'({bus.pc_en, bus.mem_write, bus.ir_write, bus.reg_write, bus.illegal_op});
        if (pin_state >= 0) chk("pin_state", int'(bus.state_o), pin_state);
        if (pin_strb >= 0)  chk("pin_strobes", strb, pin_strb);
        if (pin_alu >= 0)   chk("pin_alu", int'(bus.alu_control), pin_alu);
        if (pin_tmo >= 0)   chk("pin_timeout", int'(bus.mem_timeout), pin_tmo);
      end
    end
  end

  // One clock of stimulus; pins apply to the negedge inside this cycle.
  task automatic cycle(input bit r, input bit rdy, input bit z, input logic [5:0] o,
                       input logic [5:0] f, input int ps, input int pst, input int pa, input int pt);
    rst           = r;
    bus.mem_ready = rdy;
    bus.zero      = z;
    bus.op        = o;
    bus.funct     = f;
    if (r) model_reset();
    pin_state = ps;
    pin_strb  = pst;
    pin_alu   = pa;
    pin_tmo   = pt;
    @(posedge clk);
    model_advance();
    #1;
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;
  localparam logic [5:0] F0 = 6'b000000;

  initial begin
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] cur_op, cur_fn;
    int stall_left;

    cycle(1'b1, 1'b1, 1'b0, LW, F0, 0, 5'b00000, 2, 0);
    cycle(1'b1, 1'b0, 1'b0, LW, F0, 0, 5'b00000, 2, 0);
    // lw, zero wait states: 5 cycles, one ir_write, write-back only in MEMWB
    cycle(1'b0, 1'b1, 1'b0, LW, F0, 0, 5'b10100, 2, 0);
    cycle(1'b0, 1'b1, 1'b0, LW, F0, int'(DECODE), 5'b00000, 2, -1);
    cycle(1'b0, 1'b1, 1'b0, LW, F0, int'(MEMADR), 5'b00000, 2, -1);
    cycle(1'b0, 1'b1, 1'b0, LW, F0, int'(MEMRD), 5'b00000, -1, -1);
    cycle(1'b0, 1'b1, 1'b0, LW, F0, int'(MEMWB), 5'b00010, -1, -1);
    // R-type or
    cycle(1'b0, 1'b1, 1'b0, RT, 6'b100101, 0, 5'b10100, -1, -1);
    cycle(1'b0, 1'b1, 1'b0, RT, 6'b100101, int'(DECODE), 5'b00000, -1, -1);
    cycle(1'b0, 1'b1, 1'b0, RT, 6'b100101, int'(RTYPEEX), 5'b00000, 1, -1);
    cycle(1'b0, 1'b1, 1'b0, RT, 6'b100101, int'(RTYPEWB), 5'b00010, -1, -1);
    // beq taken then not taken
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, k == 0, BQ, F0, 0, 5'b10100, -1, -1);
      cycle(1'b0, 1'b1, k == 0, BQ, F0, int'(DECODE), 5'b00000, -1, -1);
      cycle(1'b0, 1'b1, k == 0, BQ, F0, int'(BEQEX), (k == 0) ? 5'b10000 : 5'b00000, 6, -1);
    end
    // sw with three wait states
    cycle(1'b0, 1'b1, 1'b0, SW, F0, 0, 5'b10100, -1, 0);
    cycle(1'b0, 1'b1, 1'b0, SW, F0, int'(DECODE), 5'b00000, -1, 0);
    cycle(1'b0, 1'b1, 1'b0, SW, F0, int'(MEMADR), 5'b00000, -1, 0);
    for (int k = 0; k < 4; k++)
      cycle(1'b0, k == 3, 1'b0, SW, F0, int'(MEMWR), 5'b01000, -1, 0);
    // illegal opcode, then illegal funct
    cycle(1'b0, 1'b1, 1'b0, 6'b111111, F0, 0, 5'b10100, -1, -1);
    cycle(1'b0, 1'b1, 1'b0, 6'b111111, F0, int'(DECODE), 5'b00001, -1, -1);
    cycle(1'b0, 1'b1, 1'b0, RT, 6'b000111, 0, 5'b10100, -1, -1);
    cycle(1'b0, 1'b1, 1'b0, RT, 6'b000111, int'(DECODE), 5'b00001, -1, -1);
    cycle(1'b0, 1'b0, 1'b0, RT, 6'b000111, 0, 5'b00000, -1, -1);
    // fetch stall past the timeout, then j, then reset clears the flag
    cycle(1'b1, 1'b0, 1'b0, JJ, F0, 0, 5'b00000, -1, 0);
    for (int k = 0; k < 20; k++)
      cycle(1'b0, 1'b0, 1'b0, JJ, F0, 0, 5'b00000, 2, (k >= 16) ? 1 : 0);
    cycle(1'b0, 1'b1, 1'b0, JJ, F0, 0, 5'b10100, -1, 1);
    cycle(1'b0, 1'b1, 1'b0, JJ, F0, int'(DECODE), 5'b00000, -1, 1);
    cycle(1'b0, 1'b1, 1'b0, JJ, F0, int'(JEX), 5'b10000, -1, 1);
    cycle(1'b0, 1'b0, 1'b0, JJ, F0, 0, 5'b00000, -1, 1);
    cycle(1'b1, 1'b1, 1'b0, JJ, F0, 0, 5'b00000, -1, 0);
    // reset asserted while in MEMRD
    cycle(1'b0, 1'b1, 1'b0, LW, F0, 0, 5'b10100, -1, 0);
    cycle(1'b0, 1'b1, 1'b0, LW, F0, int'(DECODE), 5'b00000, -1, -1);
    cycle(1'b0, 1'b1, 1'b0, LW, F0, int'(MEMADR), 5'b00000, -1, -1);
    cycle(1'b0, 1'b0, 1'b0, LW, F0, int'(MEMRD), 5'b00000, -1, -1);
    cycle(1'b1, 1'b1, 1'b0, LW, F0, 0, 5'b00000, 2, 0);
    cycle(1'b1, 1'b1, 1'b1, BQ, F0, 0, 5'b00000, 2, 0);
    cycle(1'b0, 1'b1, 1'b0, AI, F0, 0, 5'b10100, 2, 0);
    cycle(1'b0, 1'b1, 1'b0, AI, F0, int'(DECODE), 5'b00000, 2, 0);

    // Randomized instruction stream with stalls, bursts and occasional reset.
    cur_op = AI;
    cur_fn = F0;
    stall_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rdy, r;
      if (m_state == FETCH) begin
        case ($urandom_range(0, 7))
          0: cur_op = LW;
          1: cur_op = SW;
          2: begin cur_op = RT; cur_fn = fns[$urandom_range(0, 4)]; end
          3: cur_op = BQ;
          4: cur_op = AI;
          5: cur_op = JJ;
          6: begin cur_op = RT; cur_fn = 6'($urandom_range(0, 63)); end
          default: cur_op = 6'($urandom_range(0, 63));
        endcase
        if (cur_op != RT) cur_fn = 6'($urandom_range(0, 63));
      end
      if (stall_left == 0 && $urandom_range(0, 149) == 0) stall_left = $urandom_range(14, 22);
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 9) < 7);
      end
      r = ($urandom_range(0, 399) == 0);
      cycle(r, rdy, 1'($urandom_range(0, 1)), cur_op, cur_fn, -1, -1, -1, -1);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multi-cycle control unit for the MIPS core, instantiated inside mips_top directly upstream of the datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives every datapath mux select and write enable, and the ALU control code.
- Inserts wait states on a memory ready handshake.
- Flags illegal instructions and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: wait-state count in one memory state after which mem_timeout sets.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_en  out  1  PC register load (pcwrite | (branch & zero))
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = memory data
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  out  1  one-cycle pulse on an unsupported op/funct
- mem_timeout  out  1  sticky; cleared only by reset
- state_o  out  4  current state code, for debug

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Outputs are Moore decodes of the state. The only exceptions are the enables gated by mem_ready and zero, as stated below.
- Reset (asynchronous, may assert at any cycle mid-instruction):
  - state = FETCH, wait counter = 0, mem_timeout = 0.
  - While rst is high: pc_en, mem_write, ir_write, reg_write and illegal_op are forced to 0.
  - Mux selects show the FETCH values.
- FETCH:
  - i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_control = 010, pc_src = 00.
  - ir_write and pc_en assert only in the cycle where mem_ready = 1; that cycle moves to DECODE.
  - Otherwise FETCH holds.
- DECODE: alu_src_a = 0, alu_src_b = 11, add (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 with funct in {100000, 100010, 100100, 100101, 101010} -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JEX
  - Anything else -> FETCH with illegal_op high for this DECODE cycle. No architectural write occurs.
- MEMADR: alu_src_a = 1, alu_src_b = 10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: i_or_d = 1. Holds until mem_ready, then -> MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next -> FETCH.
- MEMWR: i_or_d = 1, mem_write = 1 held until mem_ready, then -> FETCH.
- RTYPEEX: alu_src_a = 1, alu_src_b = 00, alu_control from funct: add 010, sub 110, and 000, or 001, slt 111.
- RTYPEWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
- BEQEX: alu_src_a = 1, alu_src_b = 00, sub, pc_src = 01, pc_en = zero. Next -> FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, add.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
- JEX: pc_src = 10, pc_en = 1. Next -> FETCH.
- Latency with zero wait states:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each memory wait cycle adds one.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR, and whenever mem_ready = 1.
  - Increments each cycle the FSM is held in a memory state with mem_ready = 0, saturating at its maximum.
  - mem_timeout sets when the count reaches TIMEOUT_CYCLES. The FSM keeps waiting; timeout never aborts.
- mem_ready is ignored in every non-memory state.
- Unused output combinations default to 0. No latches.

Decomposition:
- Shared package mips_pkg holds:
  - the state enum, 4-bit encoding, FETCH = 0
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - alu_control codes
  - alu_src_b and pc_src select constants
- Sub-module mips_alu_decoder: combinational (aluop[1:0], funct) -> alu_control[2:0] plus a funct_valid output.
- The FSM drives aluop: 00 add, 01 sub, 10 funct-based.

Test Plan:
- Reset, then lw (op 100011) with mem_ready tied 1:
  - state_o sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - reg_write = 1 and mem_to_reg = 1 only in MEMWB.
  - ir_write pulses exactly once.
- R-type or (funct 100101): alu_control = 001 in RTYPEEX, reg_dst = 1 with reg_write in RTYPEWB; total 4 cycles.
- beq twice:
  - zero = 1 gives pc_en = 1 in BEQEX; zero = 0 gives pc_en = 0 in BEQEX.
  - Both return to FETCH after 3 cycles.
- sw with mem_ready low for 3 cycles in MEMWR: mem_write stays high for 4 cycles, then FETCH; mem_timeout stays 0.
- FETCH with mem_ready held low for 20 cycles:
  - mem_timeout rises after 16 wait cycles and stays high.
  - ir_write asserts only when mem_ready rises.
  - Only reset clears mem_timeout.
- Illegal instructions:
  - op 111111 in DECODE: one-cycle illegal_op, next state FETCH, no reg_write or mem_write.
  - op 000000 with funct 000111: same response.
- Reset asserted in MEMRD: state_o = 0 immediately (asynchronous), all strobes 0 while rst is high, clean fetch after release.
